// File: rtl/rv32_pkg.sv
// Shared types and defaults for the RV32I fetch-side program-counter logic.
package rv32_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_INSN_BYTES   = 4;

  // Number of low address bits that must be zero for a legal instruction address.
  function automatic int align_bits(input int insn_bytes);
    return (insn_bytes == 2) ? 1 : 2;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request channel: address plus valid/ready handshake.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0] fetch_pc;
  logic            fetch_valid;
  logic            fetch_ready;

  modport master (
    output fetch_pc,
    output fetch_valid,
    input  fetch_ready
  );

  modport slave (
    input  fetch_pc,
    input  fetch_valid,
    output fetch_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-pc / next-epc / next-state selection for pc_gen.
module pc_next_sel
  import rv32_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              INSN_BYTES  = DEFAULT_INSN_BYTES
) (
  input  pc_state_e       state,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            fetch_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            trap_ret,
  input  logic            halt,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc_next,
  output logic            misalign_next,
  output pc_state_e       state_next
);

  localparam int AB = align_bits(INSN_BYTES);

  logic target_misaligned;

  always_comb begin
    target_misaligned = |redirect_target[AB-1:0];
  end

  always_comb begin
    pc_next       = pc;
    epc_next      = epc;
    misalign_next = 1'b0;
    state_next    = state;

    if (state == ST_BOOT) begin
      state_next = ST_RUN;
    end else begin
      // Halt only steers the state; control-flow events still retarget the pc.
      state_next = halt ? ST_HALTED : ST_RUN;
      if (trap) begin
        pc_next  = TRAP_VECTOR;
        epc_next = trap_pc;
      end else if (trap_ret) begin
        pc_next = epc;
      end else if (redirect && !target_misaligned) begin
        pc_next = redirect_target;
      end else if (redirect) begin
        pc_next       = TRAP_VECTOR;
        epc_next      = redirect_target;
        misalign_next = 1'b1;
      end else if (state == ST_RUN && !halt && fetch_ready) begin
        pc_next = pc + XLEN'(INSN_BYTES);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the RV32I fetch stage: boot, handshake, redirects, traps, halt.
module pc_gen
  import rv32_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              INSN_BYTES   = DEFAULT_INSN_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_if.master        fetch,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            trap_ret,
  input  logic            halt,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSN_BYTES  (INSN_BYTES)
  ) u_next_sel (
    .state           (state_q),
    .pc              (pc_q),
    .epc             (epc_q),
    .fetch_ready     (fetch.fetch_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap            (trap),
    .trap_pc         (trap_pc),
    .trap_ret        (trap_ret),
    .halt            (halt),
    .pc_next         (pc_d),
    .epc_next        (epc_d),
    .misalign_next   (misalign_d),
    .state_next      (state_d)
  );

  // Status outputs are decoded from the next state so they leave a flop directly.
  always_comb begin
    valid_d  = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign fetch.fetch_pc    = pc_q;
  assign fetch.fetch_valid = valid_q;
  assign epc               = epc_q;
  assign misalign          = misalign_q;
  assign halted            = halted_q;

endmodule
